// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side signal bundle for alu_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the
// surrounding logic (requesters plus the registered ALU).
interface alu_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*32-1:0] req_a;
  logic [N_REQ*32-1:0] req_b;
  logic [N_REQ*4-1:0]  req_op;
  logic [N_REQ-1:0]    resp_valid;
  logic [N_REQ-1:0]    resp_ready;
  logic [31:0]         resp_data;
  logic [31:0]         alu_a;
  logic [31:0]         alu_b;
  logic [3:0]          alu_op;
  logic                alu_en;
  logic [31:0]         alu_out;

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready, alu_out,
    output req_ready, resp_valid, resp_data, alu_a, alu_b, alu_op, alu_en
  );

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready, alu_out,
    input  req_ready, resp_valid, resp_data, alu_a, alu_b, alu_op, alu_en
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU (1-cycle latency) between
// N_REQ requesters. One operation in flight: accept -> issue -> capture -> respond.
// The captured result is held for the issuing requester until it is consumed.
module alu_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] winner;
  logic            any_req;
  logic [31:0]     win_a, win_b;
  logic [3:0]      win_op;
  logic [N_REQ-1:0] ready_vec;
  logic [N_REQ-1:0] resp_valid_q;
  logic [31:0]     resp_data_q;
  logic [31:0]     alu_a_q, alu_b_q;
  logic [3:0]      alu_op_q;

  // (base + step) modulo N_REQ, for step in 0..N_REQ-1; N_REQ need not be a power of two
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return ID_W'(sum);
  endfunction

  // Round-robin pick: scan from rr_ptr upward; scanning backwards lets the nearest hit win
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[wrap_add(rr_ptr, k)]) begin
        winner  = wrap_add(rr_ptr, k);
        any_req = 1'b1;
      end
    end
  end

  // Select the winning requester's operands and op code
  always_comb begin
    win_a  = '0;
    win_b  = '0;
    win_op = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (winner == ID_W'(k)) begin
        win_a  = bus.req_a[32*k +: 32];
        win_b  = bus.req_b[32*k +: 32];
        win_op = bus.req_op[4*k +: 4];
      end
    end
  end

  // Next-state and request acceptance; only IDLE can accept
  always_comb begin
    state_nxt = state;
    ready_vec = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          ready_vec[winner] = 1'b1;
          state_nxt         = ISSUE;
        end
      end
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP: begin
        if (bus.resp_ready[grant_id]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand latch on accept, result capture, response retirement and pointer advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= '0;
      grant_id     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            alu_a_q  <= win_a;
            alu_b_q  <= win_b;
            alu_op_q <= win_op;
            grant_id <= winner;
          end
        end
        CAPTURE: begin
          resp_data_q  <= bus.alu_out;
          resp_valid_q <= N_REQ'(1) << grant_id;
        end
        RESP: begin
          if (bus.resp_ready[grant_id]) begin
            resp_valid_q <= '0;
            rr_ptr       <= wrap_add(grant_id, 1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = ready_vec;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_en     = (state == ISSUE);
endmodule
